// File: rtl/rst_seq_ctrl.sv
// Reset sequencer for the system clock domain: merges ext/sw/watchdog requests, holds all
// domain resets, then releases domains one at a time in index order and records the cause.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ASSERT  | all domains in reset, counting the hold time since the last request
// RELEASE | domains released one per gap interval, idx = last released domain
// RUN     | every domain released, rst_done_o high
module rst_seq_ctrl #(
    parameter int NumDomains = 3,
    parameter int HoldCycles = 16,
    parameter int GapCycles  = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  ext_rst_req_i,
    input  logic                  sw_rst_req_i,
    input  logic                  wdog_rst_req_i,
    input  logic                  rst_reason_clr_i,
    output logic [NumDomains-1:0] dom_rst_no,
    output logic                  rst_done_o,
    output logic [3:0]            rst_reason_o
);

    localparam int MaxCnt = (HoldCycles > GapCycles) ? HoldCycles : GapCycles;
    localparam int CntW   = (MaxCnt > 1) ? $clog2(MaxCnt) : 1;
    localparam int IdxW   = (NumDomains > 1) ? $clog2(NumDomains) : 1;

    localparam logic [CntW-1:0] HoldLast = CntW'(HoldCycles - 1);
    localparam logic [CntW-1:0] GapLast  = CntW'(GapCycles - 1);
    localparam logic [IdxW-1:0] IdxLast  = IdxW'(NumDomains - 1);

    typedef enum logic [1:0] {
        ASSERT  = 2'd0,
        RELEASE = 2'd1,
        RUN     = 2'd2
    } state_t;

    state_t          state_q;
    logic [CntW-1:0] cnt_q;
    logic [IdxW-1:0] idx_q;
    logic            started_q;
    logic            req;
    logic            restart;
    logic [3:0]      reason_d;

    assign req = ext_rst_req_i | sw_rst_req_i | wdog_rst_req_i;

    // The first edge after rst_ni rises starts the hold count exactly like a request edge,
    // so the hold window is measured from that edge rather than from reset deassertion.
    assign restart = req | ~started_q;

    // Reason layout {wdog, sw, ext, por}; clear wins over history, never over a new request.
    always_comb begin
        reason_d      = rst_reason_clr_i ? 4'b0000 : rst_reason_o;
        reason_d[3:1] = reason_d[3:1] | {wdog_rst_req_i, sw_rst_req_i, ext_rst_req_i};
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ASSERT;
            cnt_q        <= '0;
            idx_q        <= '0;
            started_q    <= 1'b0;
            dom_rst_no   <= '0;
            rst_done_o   <= 1'b0;
            rst_reason_o <= 4'b0001;
        end else begin
            started_q    <= 1'b1;
            rst_reason_o <= reason_d;
            if (restart) begin
                state_q    <= ASSERT;
                cnt_q      <= '0;
                idx_q      <= '0;
                dom_rst_no <= '0;
                rst_done_o <= 1'b0;
            end else begin
                case (state_q)
                    ASSERT: begin
                        if (cnt_q == HoldLast) begin
                            dom_rst_no <= NumDomains'(1);
                            idx_q      <= '0;
                            cnt_q      <= '0;
                            state_q    <= RELEASE;
                        end else begin
                            cnt_q <= cnt_q + CntW'(1);
                        end
                    end
                    RELEASE: begin
                        if (cnt_q == GapLast) begin
                            cnt_q <= '0;
                            if (idx_q < IdxLast) begin
                                // Released set is always a contiguous run from bit 0.
                                idx_q      <= idx_q + IdxW'(1);
                                dom_rst_no <= (dom_rst_no << 1) | NumDomains'(1);
                            end else begin
                                rst_done_o <= 1'b1;
                                state_q    <= RUN;
                            end
                        end else begin
                            cnt_q <= cnt_q + CntW'(1);
                        end
                    end
                    RUN: begin
                        state_q <= RUN;
                    end
                    default: begin
                        state_q <= ASSERT;
                        cnt_q   <= '0;
                        idx_q   <= '0;
                    end
                endcase
            end
        end
    end

endmodule
